// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential requests to a 1-cycle imem, results
// buffered in a small FIFO for decode; redirects flush and restart, halt freezes.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_instr,
  output logic              out_misalign
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] tag_pc_reg;
  logic [CW-1:0]   count_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic            inflight_reg;
  logic            stopped_reg;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic            mis_mem   [DEPTH];

  logic            aligned;
  logic            empty;
  logic            pop;
  logic            push;
  logic            issue;
  logic            req_ok;
  logic [SW-1:0]   credit;
  logic [XLEN-1:0] req_pc;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic [XLEN-1:0] wr_pc;
  logic [XLEN-1:0] wr_instr;
  logic            wr_mis;

  always_comb begin
    aligned   = (redirect_pc[1:0] == 2'b00);
    empty     = (count_reg == '0);
    out_valid = !empty && !halt && !redirect_valid;
    pop       = out_valid && out_ready;
    // Credit counts the response already in flight so the FIFO can never overflow.
    credit    = {1'b0, count_reg} + SW'(inflight_reg) - SW'(pop);
    req_ok    = (credit < SW'(DEPTH));
    req_pc    = redirect_valid ? redirect_pc : fetch_pc_reg;
    if (redirect_valid) begin
      issue = aligned && !halt;
    end else begin
      issue = req_ok && !halt && !stopped_reg;
    end
    issue     = issue && !rst;
    push      = inflight_reg && !redirect_valid;

    // A misaligned redirect writes a single marker entry into the freshly flushed FIFO.
    wr_en    = redirect_valid ? !aligned : push;
    wr_idx   = redirect_valid ? '0 : wr_ptr_reg;
    wr_pc    = redirect_valid ? redirect_pc : tag_pc_reg;
    wr_instr = redirect_valid ? '0 : imem_rdata;
    wr_mis   = redirect_valid;
  end

  assign imem_req     = issue;
  assign imem_addr    = req_pc[ADDR_W+1:2];
  assign out_pc       = empty ? '0 : pc_mem[rd_ptr_reg];
  assign out_instr    = empty ? '0 : instr_mem[rd_ptr_reg];
  assign out_misalign = empty ? 1'b0 : mis_mem[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      tag_pc_reg   <= '0;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      inflight_reg <= 1'b0;
      stopped_reg  <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        tag_pc_reg   <= req_pc;
        fetch_pc_reg <= req_pc + XLEN'(4);
      end else if (redirect_valid) begin
        fetch_pc_reg <= redirect_pc;
      end

      if (redirect_valid) begin
        stopped_reg <= !aligned;
        rd_ptr_reg  <= '0;
        wr_ptr_reg  <= aligned ? '0 : PW'(1);
        count_reg   <= aligned ? '0 : CW'(1);
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        count_reg <= count_reg + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_idx]    <= wr_pc;
      instr_mem[wr_idx] <= wr_instr;
      mis_mem[wr_idx]   <= wr_mis;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed timing scenarios plus a randomized run, all
// scored by a stream model of which PC must come next.
module tb_fetch_queue;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [XLEN-1:0]   imem_rdata;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              halt;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_instr;
  logic              out_misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_misalign(out_misalign)
  );

  // Instruction memory: word at address a holds a*4 + 0x13, one cycle latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= {{(XLEN-ADDR_W-2){1'b0}}, imem_addr, 2'b00} + 32'h13;
  end

  // Stream model: mode 0 = sequential from exp_pc, 1 = marker pending, 2 = stopped.
  logic [XLEN-1:0]   exp_pc = '0;
  logic [XLEN-1:0]   exp_instr;
  logic              exp_mis;
  int                mode = 0;
  int                pops = 0;
  logic [ADDR_W-1:0] last_req_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_pc = '0;
      mode   = 0;
    end else begin
      if (imem_req) last_req_addr = imem_addr;
      checks++;
      if (redirect_valid && out_valid) begin
        errors++;
        $display("FAIL mon_valid_on_redirect: out_valid=%0b required 0", out_valid);
      end
      if (halt) begin
        checks++;
        if (out_valid || imem_req) begin
          errors++;
          $display("FAIL mon_halt_freeze: out_valid=%0b imem_req=%0b required 0 0", out_valid, imem_req);
        end
      end
      if (mode != 0 && !redirect_valid) begin
        checks++;
        if (imem_req) begin
          errors++;
          $display("FAIL mon_stopped_req: imem_req=%0b required 0", imem_req);
        end
      end
      if (out_valid && out_ready) begin
        pops++;
        checks++;
        if (mode == 2) begin
          errors++;
          $display("FAIL mon_pop_after_marker: got pc=%h, required no delivery", out_pc);
        end else begin
          exp_instr = (mode == 1) ? '0 : exp_pc + 32'h13;
          exp_mis   = (mode == 1);
          if (out_pc !== exp_pc || out_instr !== exp_instr || out_misalign !== exp_mis) begin
            errors++;
            $display("FAIL mon_stream: got pc=%h instr=%h mis=%0b required pc=%h instr=%h mis=%0b",
                     out_pc, out_instr, out_misalign, exp_pc, exp_instr, exp_mis);
          end
          if (mode == 1) mode = 2;
          else exp_pc = exp_pc + 32'd4;
        end
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc;
        mode   = (redirect_pc[1:0] != 2'b00) ? 1 : 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: imem_req=%0b out_valid=%0b required 0 0", imem_req, out_valid);
    end
    checks++;
    if (out_pc !== '0 || out_instr !== '0 || out_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_head: pc=%h instr=%h mis=%0b required 0 0 0", out_pc, out_instr, out_misalign);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== '0) begin
      errors++;
      $display("FAIL stream_first_req: req=%0b addr=%h required 1 0", imem_req, imem_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_cycle1: out_valid=%0b required 0", out_valid);
    end
    tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== XLEN'(4*k) || out_instr !== XLEN'(4*k + 'h13)) begin
        errors++;
        $display("FAIL stream_seq: k=%0d valid=%0b pc=%h instr=%h required 1 %h %h",
                 k, out_valid, out_pc, out_instr, 4*k, 4*k + 'h13);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] span;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || (i >= 3 && imem_req !== 1'b0)) begin
        errors++;
        $display("FAIL bp_stall: i=%0d out_valid=%0b imem_req=%0b required 1 and no req after credit",
                 i, out_valid, imem_req);
      end
      tick();
    end
    span = {{(XLEN-ADDR_W-2){1'b0}}, last_req_addr, 2'b00} + 32'd4 - exp_pc;
    checks++;
    if (span !== XLEN'(DEPTH*4)) begin
      errors++;
      $display("FAIL bp_buffered: entries=%0d required %0d", span / 4, DEPTH);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_release: i=%0d out_valid=%0b required 1", i, out_valid);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    repeat (2) tick();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== ADDR_W'('h40) || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_T: req=%0b addr=%h valid=%0b required 1 40 0", imem_req, imem_addr, out_valid);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_T1: out_valid=%0b required 0", out_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h113) begin
      errors++;
      $display("FAIL redir_T2: valid=%0b pc=%h instr=%h required 1 100 113", out_valid, out_pc, out_instr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h104) begin
      errors++;
      $display("FAIL redir_T3: valid=%0b pc=%h required 1 104", out_valid, out_pc);
    end
    tick();
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL mis_T_req: imem_req=%0b required 0", imem_req);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_misalign !== 1'b1 || out_pc !== 32'h102 || out_instr !== '0) begin
      errors++;
      $display("FAIL mis_marker: valid=%0b mis=%0b pc=%h instr=%h required 1 1 102 0",
               out_valid, out_misalign, out_pc, out_instr);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL mis_stopped: i=%0d valid=%0b req=%0b required 0 0", i, out_valid, imem_req);
      end
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== ADDR_W'('h80)) begin
      errors++;
      $display("FAIL mis_restart_req: req=%0b addr=%h required 1 80", imem_req, imem_addr);
    end
    tick();
    redirect_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_misalign !== 1'b0) begin
      errors++;
      $display("FAIL mis_restart_pc: valid=%0b pc=%h mis=%0b required 1 200 0", out_valid, out_pc, out_misalign);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_pc !== 32'h204) begin
      errors++;
      $display("FAIL mis_restart_next: pc=%h required 204", out_pc);
    end
    tick();
  endtask

  task automatic test_halt();
    logic [XLEN-1:0] want;
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL halt_freeze: i=%0d valid=%0b req=%0b required 0 0", i, out_valid, imem_req);
      end
      tick();
    end
    halt = 1'b0;
    want = exp_pc;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== want) begin
      errors++;
      $display("FAIL halt_resume: valid=%0b pc=%h required 1 %h", out_valid, out_pc, want);
    end
    tick();
    repeat (4) tick();
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_redir_T: imem_req=%0b required 0", imem_req);
    end
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt_redir_hold: i=%0d req=%0b valid=%0b required 0 0", i, imem_req, out_valid);
      end
      tick();
    end
    halt = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== ADDR_W'('h10)) begin
      errors++;
      $display("FAIL halt_redir_first: req=%0b addr=%h required 1 10", imem_req, imem_addr);
    end
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
      errors++;
      $display("FAIL halt_redir_pc: valid=%0b pc=%h required 1 40", out_valid, out_pc);
    end
    tick();
  endtask

  task automatic test_async_reset();
    repeat (3) tick();
    #2;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: out_valid=%0b required 1", out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || out_pc !== '0 || out_instr !== '0 || out_misalign !== 1'b0) begin
      errors++;
      $display("FAIL areset_outputs: req=%0b valid=%0b pc=%h instr=%h mis=%0b required all 0",
               imem_req, out_valid, out_pc, out_instr, out_misalign);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== '0) begin
      errors++;
      $display("FAIL areset_restart_req: req=%0b addr=%h required 1 0", imem_req, imem_addr);
    end
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== '0) begin
      errors++;
      $display("FAIL areset_restart_pc: valid=%0b pc=%h required 1 0", out_valid, out_pc);
    end
    tick();
  endtask

  task automatic test_random();
    int halt_left = 0;
    int pops_start;
    int unsigned word;
    int unsigned low;
    pops_start = pops;
    for (int c = 0; c < 1500; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (halt_left == 0 && $urandom_range(0, 19) == 0) halt_left = $urandom_range(1, 4);
      halt = (halt_left > 0);
      if (halt_left > 0) halt_left--;
      redirect_valid = ($urandom_range(0, 29) == 0);
      word = $urandom_range(0, 'h3fff);
      low  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      redirect_pc = XLEN'((word << 2) | low);
      tick();
    end
    out_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (pops - pops_start <= 200) begin
      errors++;
      $display("FAIL random_progress: pops=%0d required > 200", pops - pops_start);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_halt();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
